// File: rtl/spi_register_responder_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_register_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

    localparam logic RW_READ   = 1'b1;
    localparam logic RW_WRITE  = 1'b0;
    localparam int   ERR_CNT_W = 8;

    function automatic int frame_len(input int package_size);
        return 2 * package_size;
    endfunction

endpackage

// File: rtl/spi_register_responder_input_sync.sv
// Brings sclk/csb/sdi into the clk domain and derives single-cycle edge pulses.
module spi_input_sync (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic csb,
    input  logic sdi,
    output logic sdi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csb_fall,
    output logic csb_rise
);

    // [0],[1] form the synchronizer; [2] is the previous sample for edge detection
    logic [2:0] sclk_pipe;
    logic [2:0] csb_pipe;
    logic [1:0] sdi_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_pipe <= '0;
            csb_pipe  <= '1;
            sdi_pipe  <= '0;
        end else begin
            sclk_pipe <= {sclk_pipe[1:0], sclk};
            csb_pipe  <= {csb_pipe[1:0], csb};
            sdi_pipe  <= {sdi_pipe[0], sdi};
        end
    end

    assign sdi_s     = sdi_pipe[1];
    assign sclk_rise =  sclk_pipe[1] & ~sclk_pipe[2];
    assign sclk_fall = ~sclk_pipe[1] &  sclk_pipe[2];
    assign csb_fall  = ~csb_pipe[1]  &  csb_pipe[2];
    assign csb_rise  =  csb_pipe[1]  & ~csb_pipe[2];

endmodule

// File: rtl/spi_register_responder.sv
// SPI mode-0 target mapping {rw, addr, data} frames onto a local register bank.
// Optional SPI_RESP_ERR_CNT_EN adds a saturating aborted/overlong-frame counter.
module spi_register_responder
    import spi_register_responder_pkg::*;
#(
    parameter int PACKAGE_SIZE = 8,
    parameter int NUM_REGS     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sclk,
    input  logic                    csb,
    input  logic                    sdi,
    output logic                    sdo,
    input  logic [PACKAGE_SIZE-2:0] loc_addr,
    output logic [PACKAGE_SIZE-1:0] loc_data,
    output logic                    wr_strobe,
    output logic [PACKAGE_SIZE-2:0] wr_addr,
    output logic [PACKAGE_SIZE-1:0] wr_data,
`ifdef SPI_RESP_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0]    err_count,
`endif
    output logic                    frame_active
);

    localparam int ADDR_W    = PACKAGE_SIZE - 1;
    localparam int FRAME_LEN = frame_len(PACKAGE_SIZE);
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PACKAGE_SIZE - 1);

    logic sdi_s, sclk_rise, sclk_fall, csb_fall, csb_rise;

    spi_input_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .csb       (csb),
        .sdi       (sdi),
        .sdi_s     (sdi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csb_fall  (csb_fall),
        .csb_rise  (csb_rise)
    );

    spi_state_e              state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [ADDR_W-1:0]       hdr_sr;
    logic [PACKAGE_SIZE-2:0] data_sr;
    logic [PACKAGE_SIZE-1:0] tx_sr;
    logic                    rw_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [PACKAGE_SIZE-1:0] regs [NUM_REGS];

    logic [PACKAGE_SIZE-1:0] hdr_next;
    logic [PACKAGE_SIZE-1:0] data_next;
    logic [PACKAGE_SIZE-1:0] hdr_rd_val;
    logic                    wr_in_range;

    // hdr_next = {rw, addr} once the final address bit is shifted in
    assign hdr_next    = {hdr_sr, sdi_s};
    assign data_next   = {data_sr, sdi_s};
    assign wr_in_range = int'(addr_q) < NUM_REGS;

    always_comb begin
        hdr_rd_val = '0;
        loc_data   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_next[ADDR_W-1:0] == ADDR_W'(i)) hdr_rd_val = regs[i];
            if (loc_addr == ADDR_W'(i))             loc_data   = regs[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            hdr_sr       <= '0;
            data_sr      <= '0;
            tx_sr        <= '0;
            rw_q         <= RW_WRITE;
            addr_q       <= '0;
            sdo          <= 1'b0;
            wr_strobe    <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            frame_active <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (csb_fall) begin
                        state        <= ST_ADDR;
                        bit_cnt      <= '0;
                        frame_active <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (csb_rise) begin
                        state        <= ST_IDLE;
                        frame_active <= 1'b0;
                    end else if (sclk_rise) begin
                        hdr_sr <= hdr_next[ADDR_W-1:0];
                        if (bit_cnt == LAST_BIT) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            rw_q    <= hdr_next[PACKAGE_SIZE-1];
                            addr_q  <= hdr_next[ADDR_W-1:0];
                            tx_sr   <= (hdr_next[PACKAGE_SIZE-1] == RW_READ) ? hdr_rd_val : '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (csb_rise) begin
                        state        <= ST_IDLE;
                        frame_active <= 1'b0;
                        sdo          <= 1'b0;
                    end else begin
                        // first fall after the address phase presents the MSB
                        if (sclk_fall && rw_q == RW_READ) begin
                            sdo   <= tx_sr[PACKAGE_SIZE-1];
                            tx_sr <= {tx_sr[PACKAGE_SIZE-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            data_sr <= data_next[PACKAGE_SIZE-2:0];
                            if (bit_cnt == LAST_BIT) begin
                                state <= ST_DONE;
                                sdo   <= 1'b0;
                                if (rw_q == RW_WRITE && wr_in_range) begin
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= addr_q;
                                    wr_data   <= data_next;
                                    for (int i = 0; i < NUM_REGS; i++)
                                        if (addr_q == ADDR_W'(i)) regs[i] <= data_next;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (csb_rise) begin
                        state        <= ST_IDLE;
                        frame_active <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_RESP_ERR_CNT_EN
    logic err_seen;
    logic err_evt;

    // err_seen keeps an overlong frame from counting once per extra edge
    assign err_evt = ((state == ST_ADDR || state == ST_DATA) && csb_rise) ||
                     (state == ST_DONE && !csb_rise && sclk_rise && !err_seen);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
            err_seen  <= 1'b0;
        end else begin
            if (state == ST_IDLE && csb_fall) err_seen <= 1'b0;
            else if (err_evt)                 err_seen <= 1'b1;
            if (err_evt && err_count != '1)   err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule
